fwd_scoreboard: RTL
===================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NPIPE, 2, issue pipes; pipe 0 is oldest in program order within a cycle.
- DEPTH, 7, result-propagation stages 1..DEPTH; stage DEPTH is write-back.
- NRD, 5, operand lookup ports.
- DW, 128, data width.
- AW, 7, register address width.
- FLUSH_STAGES, 1, stages 1..FLUSH_STAGES squashed by flush.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- iss_valid, in, NPIPE, instruction enters stage 1 at next edge.
- iss_wr_en, in, NPIPE, instruction writes rt.
- iss_rt, in, NPIPE x AW, destination register.
- comp_valid, in, NPIPE, result delivered this cycle.
- comp_stage, in, NPIPE x clog2(DEPTH+1), stage (1..DEPTH-1) that owns the result.
- comp_data, in, NPIPE x DW, result value.
- flush, in, 1, branch-taken squash.
- rd_addr, in, NRD x AW, operand address.
- rd_rf_data, in, NRD x DW, register-file value.
- rd_data, out, NRD x DW, forwarded operand.
- rd_hit, out, NRD, operand came from the pipeline.
- stall, out, 1, some operand matches an unready entry.
- wb_valid, out, NPIPE, write-back strobe.
- wb_rt, out, NPIPE x AW, write-back address.
- wb_data, out, NPIPE x DW, write-back data.
- err_orphan, out, 1, sticky: completion targeted an empty or non-writing entry.
- err_late, out, 1, sticky: writing entry reached DEPTH unready.

Function
REQ-003 Entry fields are {valid, wr_en, ready, rt, data}, held per pipe per stage.
REQ-004 Each edge: stage s+1 takes stage s for s = 1..DEPTH-1; stage 1 takes {iss_valid, iss_wr_en, 0, iss_rt, 0}.
REQ-005 A comp_valid[p] with comp_stage[p]==s loads comp_data into the entry moving out of stage s (arrives at s+1) and sets ready.
REQ-006 A completion to an invalid or wr_en=0 entry, or with stage 0 or stage >= DEPTH, is discarded and sets err_orphan.
REQ-007 wb_valid[p] = valid & wr_en & ready of stage DEPTH; wb_rt and wb_data come from that entry; outputs are combinational from registers.
REQ-008 A writing entry at stage DEPTH with ready=0 sets err_late, and its write-back is suppressed.
REQ-009 Lookup is combinational. Candidates are valid & wr_en entries, stages 1..DEPTH, whose rt equals rd_addr.
REQ-010 Lookup priority: lowest stage index wins; within a stage, highest pipe index wins.
REQ-011 If the winning candidate is ready: rd_data = its data and rd_hit = 1. If it is not ready: stall = 1, rd_hit = 0 and rd_data = rd_rf_data. With no candidate: rd_data = rd_rf_data and rd_hit = 0.
REQ-012 stall is the OR over all ports of unready winners; the block does not hold issue, the issuer must deassert iss_valid.
REQ-013 flush clears valid in stages 1..FLUSH_STAGES at the edge, and the current-cycle issue is dropped; entries at FLUSH_STAGES+1 and beyond continue.
REQ-014 A completion in the same cycle as flush, to a squashed stage, is discarded without an error.
REQ-015 Same-rt write-back on two pipes in one cycle: both strobes assert; the register file gives the higher pipe priority.

Reset
REQ-016 When reset is asserted at an edge, all valid, ready, err_orphan and err_late bits clear; data and rt are don't-care.
REQ-017 While reset is asserted, wb_valid = 0, stall = 0, rd_hit = 0 and rd_data = rd_rf_data.
REQ-018 Reset mid-operation discards all in-flight entries with no write-back.

Structure
REQ-019 The shared descriptions package holds the entry struct typedef and default constants; clog2 widths are derived locally.
REQ-020 One sub-module, fwd_stage_row, holds one stage across NPIPE pipes (shift, completion load, flush clear); it is instantiated DEPTH times by generate.

Verification
REQ-021 Issue p0 rt=5 lat 2; complete comp_stage=2 data=0xAA..; lookup rd_addr=5 at stage 3 -> rd_hit=1, rd_data=0xAA..; wb_valid[0] at stage 7 with rt=5.
REQ-022 Lookup rt=5 while the stage-1 entry is unready -> stall=1, rd_data=rd_rf_data.
REQ-023 p0 and p1 both issue rt=9, both complete -> lookup returns the p1 data; a younger stage-1 rt=9 entry overrides an older stage-4 entry.
REQ-024 flush with entries at stages 1 and 2, FLUSH_STAGES=1 -> stage-1 entry never writes back; stage-2 entry writes back normally.
REQ-025 Completion to an empty stage 3 -> err_orphan=1 and stays set; a writing entry never completed -> err_late=1 and no wb_valid.
REQ-026 Assert reset with 4 entries in flight -> no wb_valid afterward; errors cleared; run at NPIPE=3, DEPTH=4.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and default sizing for the result-forwarding scoreboard.
// Widths derived from parameters (clog2 of the stage count) live in the modules.
package fwd_scoreboard_pkg;

  localparam int DEF_NPIPE        = 2;
  localparam int DEF_DEPTH        = 7;
  localparam int DEF_NRD          = 5;
  localparam int DEF_DW           = 128;
  localparam int DEF_AW           = 7;
  localparam int DEF_FLUSH_STAGES = 1;

  // Control part of a pipeline entry; rt and data ride alongside at module widths.
  typedef struct packed {
    logic valid;
    logic wr_en;
    logic ready;
  } entry_ctl_t;

  function automatic logic writes_rt(input entry_ctl_t c);
    return c.valid & c.wr_en;
  endfunction

endpackage

// File: rtl/fwd_stage_row.sv
// One propagation stage across all pipes: captures the entry leaving the stage
// above (or the issue slot), merging in completions and applying flush squash.
module fwd_stage_row
  import fwd_scoreboard_pkg::*;
#(
  parameter int NPIPE        = DEF_NPIPE,
  parameter int DW           = DEF_DW,
  parameter int AW           = DEF_AW,
  parameter int SW           = 3,
  parameter int STAGE        = 1,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int FLUSH_STAGES = DEF_FLUSH_STAGES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  entry_ctl_t [NPIPE-1:0]         prev_ctl_i,
  input  logic       [NPIPE-1:0][AW-1:0] prev_rt_i,
  input  logic       [NPIPE-1:0][DW-1:0] prev_data_i,
  input  logic       [NPIPE-1:0]         comp_valid_i,
  input  logic       [NPIPE-1:0][SW-1:0] comp_stage_i,
  input  logic       [NPIPE-1:0][DW-1:0] comp_data_i,
  output entry_ctl_t [NPIPE-1:0]         ctl_o,
  output logic       [NPIPE-1:0][AW-1:0] rt_o,
  output logic       [NPIPE-1:0][DW-1:0] data_o,
  output logic       [NPIPE-1:0]         orphan_o
);

  // UP is the stage the incoming entry is leaving; 0 means the issue slot.
  localparam int UP       = STAGE - 1;
  localparam bit LOADABLE = (UP >= 1) && (UP < DEPTH);
  localparam bit SQUASH   = (UP <= FLUSH_STAGES);

  entry_ctl_t [NPIPE-1:0]         ctl_q, ctl_d;
  logic       [NPIPE-1:0][AW-1:0] rt_q;
  logic       [NPIPE-1:0][DW-1:0] data_q, data_d;

  // NOTE: every output of a combinational block gets a default up front so no
  // path through the branches leaves it unassigned and infers a latch.
  always_comb begin
    ctl_d    = prev_ctl_i;
    data_d   = prev_data_i;
    orphan_o = '0;
    for (int p = 0; p < NPIPE; p++) begin
      if (LOADABLE && comp_valid_i[p] && (comp_stage_i[p] == SW'(UP))) begin
        if (!(flush && SQUASH)) begin
          if (writes_rt(prev_ctl_i[p])) begin
            data_d[p]       = comp_data_i[p];
            ctl_d[p].ready  = 1'b1;
          end else begin
            orphan_o[p] = 1'b1;
          end
        end
      end
      if (flush && SQUASH) ctl_d[p].valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ctl_q <= '0;
    else       ctl_q <= ctl_d;
  end

  // NOTE: rt/data are deliberately left unreset; nothing reads them unless the
  // matching valid bit, which is reset, says the entry is live.
  always_ff @(posedge clock) begin
    rt_q   <= prev_rt_i;
    data_q <= data_d;
  end

  assign ctl_o  = ctl_q;
  assign rt_o   = rt_q;
  assign data_o = data_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Result-forwarding scoreboard: tracks in-flight results per pipe and stage,
// forwards the youngest matching value to operand lookups, and writes back.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NPIPE        = DEF_NPIPE,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int NRD          = DEF_NRD,
  parameter int DW           = DEF_DW,
  parameter int AW           = DEF_AW,
  parameter int FLUSH_STAGES = DEF_FLUSH_STAGES
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NPIPE-1:0]                        iss_valid,
  input  logic [NPIPE-1:0]                        iss_wr_en,
  input  logic [NPIPE-1:0][AW-1:0]                iss_rt,
  input  logic [NPIPE-1:0]                        comp_valid,
  input  logic [NPIPE-1:0][$clog2(DEPTH+1)-1:0]   comp_stage,
  input  logic [NPIPE-1:0][DW-1:0]                comp_data,
  input  logic                                    flush,
  input  logic [NRD-1:0][AW-1:0]                  rd_addr,
  input  logic [NRD-1:0][DW-1:0]                  rd_rf_data,
  output logic [NRD-1:0][DW-1:0]                  rd_data,
  output logic [NRD-1:0]                          rd_hit,
  output logic                                    stall,
  output logic [NPIPE-1:0]                        wb_valid,
  output logic [NPIPE-1:0][AW-1:0]                wb_rt,
  output logic [NPIPE-1:0][DW-1:0]                wb_data,
  output logic                                    err_orphan,
  output logic                                    err_late
);

  localparam int SW = $clog2(DEPTH + 1);

  entry_ctl_t [NPIPE-1:0]         iss_ctl;
  entry_ctl_t [NPIPE-1:0]         cur_ctl    [1:DEPTH];
  logic       [NPIPE-1:0][AW-1:0] cur_rt     [1:DEPTH];
  logic       [NPIPE-1:0][DW-1:0] cur_data   [1:DEPTH];
  logic       [NPIPE-1:0]         row_orphan [1:DEPTH];

  logic            orphan_any, late_any;
  logic            err_orphan_q, err_orphan_d;
  logic            err_late_q, err_late_d;
  logic            found, win_ready;
  logic [DW-1:0]   win_data;

  // Flush drops the issue slot inside row 1, like any other squashed stage.
  always_comb begin
    iss_ctl = '0;
    for (int p = 0; p < NPIPE; p++) begin
      iss_ctl[p].valid = iss_valid[p];
      iss_ctl[p].wr_en = iss_wr_en[p];
    end
  end

  for (genvar s = 1; s <= DEPTH; s++) begin : g_row
    entry_ctl_t [NPIPE-1:0]         in_ctl;
    logic       [NPIPE-1:0][AW-1:0] in_rt;
    logic       [NPIPE-1:0][DW-1:0] in_data;

    if (s == 1) begin : g_head
      assign in_ctl  = iss_ctl;
      assign in_rt   = iss_rt;
      assign in_data = '0;
    end else begin : g_body
      assign in_ctl  = cur_ctl[s-1];
      assign in_rt   = cur_rt[s-1];
      assign in_data = cur_data[s-1];
    end

    fwd_stage_row #(
      .NPIPE        (NPIPE),
      .DW           (DW),
      .AW           (AW),
      .SW           (SW),
      .STAGE        (s),
      .DEPTH        (DEPTH),
      .FLUSH_STAGES (FLUSH_STAGES)
    ) u_row (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .prev_ctl_i   (in_ctl),
      .prev_rt_i    (in_rt),
      .prev_data_i  (in_data),
      .comp_valid_i (comp_valid),
      .comp_stage_i (comp_stage),
      .comp_data_i  (comp_data),
      .ctl_o        (cur_ctl[s]),
      .rt_o         (cur_rt[s]),
      .data_o       (cur_data[s]),
      .orphan_o     (row_orphan[s])
    );
  end

  // Out-of-range stages are caught here; rows only judge in-range targets.
  always_comb begin
    orphan_any = 1'b0;
    late_any   = 1'b0;
    for (int p = 0; p < NPIPE; p++) begin
      if (comp_valid[p] && ((comp_stage[p] == '0) || (comp_stage[p] >= SW'(DEPTH))))
        orphan_any = 1'b1;
      if (writes_rt(cur_ctl[DEPTH][p]) && !cur_ctl[DEPTH][p].ready)
        late_any = 1'b1;
    end
    for (int s = 1; s <= DEPTH; s++) orphan_any = orphan_any | (|row_orphan[s]);
  end

  assign err_orphan_d = err_orphan_q | orphan_any;
  assign err_late_d   = err_late_q | late_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_orphan_q <= 1'b0;
      err_late_q   <= 1'b0;
    end else begin
      err_orphan_q <= err_orphan_d;
      err_late_q   <= err_late_d;
    end
  end

  assign err_orphan = err_orphan_q;
  assign err_late   = err_late_q;

  always_comb begin
    wb_valid = '0;
    for (int p = 0; p < NPIPE; p++)
      wb_valid[p] = !reset && writes_rt(cur_ctl[DEPTH][p]) && cur_ctl[DEPTH][p].ready;
  end

  assign wb_rt   = cur_rt[DEPTH];
  assign wb_data = cur_data[DEPTH];

  // Scanning oldest stage first and pipe 0 first lets the last match win,
  // giving lowest stage, then highest pipe, the priority.
  always_comb begin
    rd_data   = rd_rf_data;
    rd_hit    = '0;
    stall     = 1'b0;
    found     = 1'b0;
    win_ready = 1'b0;
    win_data  = '0;
    for (int r = 0; r < NRD; r++) begin
      found     = 1'b0;
      win_ready = 1'b0;
      win_data  = '0;
      for (int s = DEPTH; s >= 1; s--) begin
        for (int p = 0; p < NPIPE; p++) begin
          if (writes_rt(cur_ctl[s][p]) && (cur_rt[s][p] == rd_addr[r])) begin
            found     = 1'b1;
            win_ready = cur_ctl[s][p].ready;
            win_data  = cur_data[s][p];
          end
        end
      end
      if (found && !reset) begin
        if (win_ready) begin
          rd_data[r] = win_data;
          rd_hit[r]  = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule
